// File: rtl/line_fetch_if.sv
// Instruction-memory read channel between line_fetch (master) and the memory (slave).
// req/gnt handshake for the request, rvld/rdata/rerr for the in-order response.
interface line_fetch_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned BUS_WID = 64
);
  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvld;
  logic [BUS_WID-1:0] imem_rdata;
  logic               imem_rerr;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvld, imem_rdata, imem_rerr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvld, imem_rdata, imem_rerr
  );
endinterface

// File: rtl/line_fetch.sv
// Line-aligned instruction fetcher: one outstanding request, one-cycle line_vld per returned
// line, buffer_free back-pressure, jump redirect with stale-response dropping.
module line_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     BUS_WID  = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_vld,
  input  logic [XLEN-1:0]    jump_pc,
  input  logic               buffer_free,
  line_fetch_if.master       imem,
  output logic               line_vld,
  output logic [BUS_WID-1:0] line_data,
  output logic               line_err
);
  localparam int unsigned     LB        = BUS_WID / 8;
  localparam logic [XLEN-1:0] LINE_MASK = ~(XLEN'(LB - 1));
  localparam logic [XLEN-1:0] LINE_STEP = XLEN'(LB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_addr;
  logic            stale;
  logic            issue;

  // Issue is combinational so a same-cycle grant can skip REQ entirely.
  assign issue          = rst && (state == IDLE) && buffer_free && !line_vld && !jump_vld;
  assign imem.imem_req  = issue || (state == REQ);
  assign imem.imem_addr = (state == IDLE) ? (fetch_pc & LINE_MASK) : req_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      req_addr  <= RESET_PC & LINE_MASK;
      stale     <= 1'b0;
      line_vld  <= 1'b0;
      line_data <= '0;
      line_err  <= 1'b0;
    end else begin
      line_vld <= 1'b0;
      if (jump_vld) fetch_pc <= jump_pc;
      case (state)
        IDLE: begin
          if (issue) begin
            req_addr <= fetch_pc & LINE_MASK;
            stale    <= 1'b0;
            state    <= imem.imem_gnt ? WAIT : REQ;
          end
        end
        REQ: begin
          if (jump_vld) stale <= 1'b1;
          if (imem.imem_gnt) begin
            stale <= 1'b0;
            state <= (jump_vld || stale) ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvld) begin
            if (!jump_vld) begin
              line_vld  <= 1'b1;
              line_data <= imem.imem_rdata;
              line_err  <= imem.imem_rerr;
              fetch_pc  <= (fetch_pc & LINE_MASK) + LINE_STEP;
            end
            state <= IDLE;
          end else if (jump_vld) begin
            state <= DROP;
          end
        end
        DROP: begin
          // A jump coinciding with the stale response still retires it; waiting on would hang.
          if (imem.imem_rvld) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
